// File: rtl/c_sram_pingpong_ctrl.sv
// Multi-bank ping-pong store for systolic-array C tiles: bitmap-tracked completion, single/row-burst reads.
// Optional macro C_SRAM_PARITY_EN adds an even-parity bit per stored word, checked on every read beat.
module c_sram_pingpong_ctrl #(
  parameter int M      = 8,
  parameter int N      = 8,
  parameter int DATA_W = 32,
  parameter int NBANK  = 2,
  parameter int ROW_W  = (M <= 1) ? 1 : $clog2(M),
  parameter int COL_W  = (N <= 1) ? 1 : $clog2(N),
  parameter int BANK_W = (NBANK <= 1) ? 1 : $clog2(NBANK)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [M*N*DATA_W-1:0] c_out_flat,
  input  logic [M*N-1:0]        c_valid_flat,
  output logic [BANK_W-1:0]     wr_bank,
  output logic [NBANK-1:0]      bank_full,
  output logic                  tile_done,
  output logic                  start_err,
  output logic                  drop_err,
  input  logic                  rd_req,
  output logic                  rd_ready,
  input  logic [BANK_W-1:0]     rd_bank,
  input  logic [ROW_W-1:0]      rd_row,
  input  logic [COL_W-1:0]      rd_col,
  input  logic                  rd_burst,
  output logic [DATA_W-1:0]     rd_rdata,
  output logic                  rd_rvalid,
  output logic                  rd_rlast,
  output logic                  rd_rerr,
  output logic                  rd_perr,
  input  logic                  rel,
  input  logic [BANK_W-1:0]     rel_bank,
  output logic                  rel_err
);

  localparam int NE   = M * N;
  localparam int EW   = (NE <= 1) ? 1 : $clog2(NE);

  typedef enum logic [1:0] {B_EMPTY = 2'd0, B_FILLING = 2'd1, B_FULL = 2'd2} bank_st_e;
  typedef enum logic {RD_IDLE = 1'b0, RD_BURST = 1'b1} rd_st_e;

  bank_st_e          bst_q [NBANK];
  bank_st_e          bst_d [NBANK];
  logic [NE-1:0]     bitmap_q, bitmap_d;
  logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
  logic              tile_done_q, tile_done_d;
  logic              start_err_q, start_err_d;
  logic              drop_err_q, drop_err_d;
  logic              rel_err_q, rel_err_d;
  rd_st_e            rd_st_q, rd_st_d;
  logic [BANK_W-1:0] rdb_q, rdb_d;
  logic [ROW_W-1:0]  rdr_q, rdr_d;
  logic [COL_W-1:0]  rdc_q, rdc_d;
  logic              rd_ready_q, rd_ready_d;
  logic [DATA_W-1:0] rd_rdata_q, rd_rdata_d;
  logic              rd_rvalid_q, rd_rvalid_d;
  logic              rd_rlast_q, rd_rlast_d;
  logic              rd_rerr_q, rd_rerr_d;
  logic              rd_perr_q, rd_perr_d;

  logic [DATA_W-1:0] mem_q [NBANK][NE];
`ifdef C_SRAM_PARITY_EN
  logic              par_q [NBANK][NE];

  function automatic logic even_par(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction
`endif

  logic [NE-1:0]     vclean_s;
  logic              wr_act_s;
  logic [BANK_W-1:0] wr_tgt_s;
  logic [BANK_W-1:0] nb_s;
  logic              burst_busy_s;
  logic              rd_ok_s;
  logic              rd_do_s;
  logic [BANK_W-1:0] rd_bsel_s;
  logic [EW-1:0]     rd_idx_s;

  // X/Z strobes must never write; only a clean 1 counts
  always_comb begin
    for (int e = 0; e < NE; e++) begin
      vclean_s[e] = (c_valid_flat[e] === 1'b1);
    end
  end

  // Bank lifecycle: release first, then start, then this cycle's writes and completion
  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      bst_d[b] = bst_q[b];
    end
    bitmap_d    = bitmap_q;
    wr_bank_d   = wr_bank_q;
    tile_done_d = 1'b0;
    start_err_d = 1'b0;
    drop_err_d  = 1'b0;
    rel_err_d   = 1'b0;
    nb_s = (int'(wr_bank_q) == NBANK - 1) ? {BANK_W{1'b0}} : wr_bank_q + BANK_W'(1);
    burst_busy_s = ((rd_st_q == RD_BURST) && (rdb_q == rel_bank)) ||
                   ((rd_st_q == RD_IDLE) && rd_req && rd_burst && (rd_bank == rel_bank));

    if (rel) begin
      if ((int'(rel_bank) < NBANK) && (bst_q[rel_bank] == B_FULL) && !burst_busy_s) begin
        bst_d[rel_bank] = B_EMPTY;
      end else begin
        rel_err_d = 1'b1;
      end
    end else begin
      rel_err_d = 1'b0;
    end

    if (start) begin
      if (bst_d[nb_s] == B_EMPTY) begin
        for (int b = 0; b < NBANK; b++) begin
          if (bst_d[b] == B_FILLING) bst_d[b] = B_EMPTY;
          else                       bst_d[b] = bst_d[b];
        end
        bst_d[nb_s] = B_FILLING;
        bitmap_d    = {NE{1'b0}};
        wr_bank_d   = nb_s;
      end else begin
        start_err_d = 1'b1;
      end
    end else begin
      start_err_d = 1'b0;
    end

    // Only the most recently opened bank can be FILLING
    wr_tgt_s = wr_bank_d;
    wr_act_s = (bst_d[wr_bank_d] == B_FILLING);
    if (|vclean_s) begin
      if (wr_act_s) begin
        bitmap_d = bitmap_d | vclean_s;
        if (&bitmap_d) begin
          bst_d[wr_bank_d] = B_FULL;
          tile_done_d      = 1'b1;
        end else begin
          tile_done_d = 1'b0;
        end
      end else begin
        drop_err_d = 1'b1;
      end
    end else begin
      drop_err_d = 1'b0;
    end
  end

  // Read FSM: every beat is registered, so data appears one cycle after acceptance
  always_comb begin
    rd_st_d     = rd_st_q;
    rdb_d       = rdb_q;
    rdr_d       = rdr_q;
    rdc_d       = rdc_q;
    rd_rvalid_d = 1'b0;
    rd_rlast_d  = 1'b0;
    rd_rerr_d   = 1'b0;
    rd_rdata_d  = {DATA_W{1'b0}};
    rd_perr_d   = 1'b0;
    rd_do_s     = 1'b0;
    rd_bsel_s   = rd_bank;
    rd_idx_s    = {EW{1'b0}};
    rd_ok_s     = (int'(rd_bank) < NBANK) && (int'(rd_row) < M) &&
                  (rd_burst || (int'(rd_col) < N)) && (bst_q[rd_bank] == B_FULL);
    case (rd_st_q)
      RD_IDLE: begin
        if (rd_req) begin
          rd_rvalid_d = 1'b1;
          if (!rd_ok_s) begin
            rd_rerr_d  = 1'b1;
            rd_rlast_d = 1'b1;
          end else if (rd_burst && (N > 1)) begin
            rd_do_s  = 1'b1;
            rd_idx_s = EW'(int'(rd_row) * N);
            rdb_d    = rd_bank;
            rdr_d    = rd_row;
            rdc_d    = COL_W'(1);
            rd_st_d  = RD_BURST;
          end else begin
            rd_do_s    = 1'b1;
            rd_idx_s   = EW'(int'(rd_row) * N + (rd_burst ? 0 : int'(rd_col)));
            rd_rlast_d = 1'b1;
          end
        end else begin
          rd_st_d = RD_IDLE;
        end
      end
      RD_BURST: begin
        rd_rvalid_d = 1'b1;
        rd_do_s     = 1'b1;
        rd_bsel_s   = rdb_q;
        rd_idx_s    = EW'(int'(rdr_q) * N + int'(rdc_q));
        if (int'(rdc_q) == N - 1) begin
          rd_rlast_d = 1'b1;
          rd_st_d    = RD_IDLE;
        end else begin
          rdc_d = rdc_q + COL_W'(1);
        end
      end
      default: rd_st_d = RD_IDLE;
    endcase
    if (rd_do_s) begin
      rd_rdata_d = mem_q[rd_bsel_s][rd_idx_s];
`ifdef C_SRAM_PARITY_EN
      rd_perr_d  = (even_par(mem_q[rd_bsel_s][rd_idx_s]) != par_q[rd_bsel_s][rd_idx_s]);
`else
      rd_perr_d  = 1'b0;
`endif
    end else begin
      rd_rdata_d = {DATA_W{1'b0}};
    end
    rd_ready_d = (rd_st_d == RD_IDLE);
  end

  // Control and read-port registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NBANK; b++) bst_q[b] <= B_EMPTY;
      bitmap_q    <= {NE{1'b0}};
      wr_bank_q   <= BANK_W'(NBANK - 1);
      tile_done_q <= 1'b0;
      start_err_q <= 1'b0;
      drop_err_q  <= 1'b0;
      rel_err_q   <= 1'b0;
      rd_st_q     <= RD_IDLE;
      rdb_q       <= {BANK_W{1'b0}};
      rdr_q       <= {ROW_W{1'b0}};
      rdc_q       <= {COL_W{1'b0}};
      rd_ready_q  <= 1'b1;
      rd_rdata_q  <= {DATA_W{1'b0}};
      rd_rvalid_q <= 1'b0;
      rd_rlast_q  <= 1'b0;
      rd_rerr_q   <= 1'b0;
      rd_perr_q   <= 1'b0;
    end else begin
      for (int b = 0; b < NBANK; b++) bst_q[b] <= bst_d[b];
      bitmap_q    <= bitmap_d;
      wr_bank_q   <= wr_bank_d;
      tile_done_q <= tile_done_d;
      start_err_q <= start_err_d;
      drop_err_q  <= drop_err_d;
      rel_err_q   <= rel_err_d;
      rd_st_q     <= rd_st_d;
      rdb_q       <= rdb_d;
      rdr_q       <= rdr_d;
      rdc_q       <= rdc_d;
      rd_ready_q  <= rd_ready_d;
      rd_rdata_q  <= rd_rdata_d;
      rd_rvalid_q <= rd_rvalid_d;
      rd_rlast_q  <= rd_rlast_d;
      rd_rerr_q   <= rd_rerr_d;
      rd_perr_q   <= rd_perr_d;
    end
  end

  // Tile storage is not reset; an EMPTY bank simply cannot be read
  always_ff @(posedge clk) begin
    for (int b = 0; b < NBANK; b++) begin
      for (int e = 0; e < NE; e++) begin
        if (wr_act_s && (wr_tgt_s == BANK_W'(b)) && vclean_s[e]) begin
          mem_q[b][e] <= c_out_flat[e*DATA_W +: DATA_W];
`ifdef C_SRAM_PARITY_EN
          par_q[b][e] <= even_par(c_out_flat[e*DATA_W +: DATA_W]);
`endif
        end
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      bank_full[b] = (bst_q[b] == B_FULL);
    end
  end

  assign wr_bank   = wr_bank_q;
  assign tile_done = tile_done_q;
  assign start_err = start_err_q;
  assign drop_err  = drop_err_q;
  assign rel_err   = rel_err_q;
  assign rd_ready  = rd_ready_q;
  assign rd_rdata  = rd_rdata_q;
  assign rd_rvalid = rd_rvalid_q;
  assign rd_rlast  = rd_rlast_q;
  assign rd_rerr   = rd_rerr_q;
  assign rd_perr   = rd_perr_q;

endmodule
